// File: rtl/monolith_pkg.sv
// Shared types and constants for the Monolith permutation datapath.
package monolith_pkg;

    localparam int DEFAULT_WORD_WIDTH = 31;
    localparam int DEFAULT_STATE_SIZE = 16;
    localparam int DEFAULT_NUM_ROUNDS = 6;
    localparam logic [30:0] PRIME     = 31'h7FFFFFFF;

    typedef logic [DEFAULT_WORD_WIDTH-1:0] state_t [DEFAULT_STATE_SIZE];

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT,
        S_DONE,
        S_FAIL
    } ctrl_state_t;

endpackage

// File: rtl/monolith_perm_ctrl.sv
// Sequences the pre-round plus NUM_ROUNDS full rounds on the shared round
// engine, fetching per-round constants from the external ROM.
module monolith_perm_ctrl
    import monolith_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int STATE_SIZE = DEFAULT_STATE_SIZE,
    parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS,
    parameter int TIMEOUT    = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WORD_WIDTH*STATE_SIZE-1:0]    in_state,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WORD_WIDTH*STATE_SIZE-1:0]    out_state,
    output logic                                error,
    output logic [$clog2(NUM_ROUNDS)-1:0]       rc_addr,
    input  logic [WORD_WIDTH*STATE_SIZE-1:0]    rc_data,
    output logic                                rnd_reset,
    output logic                                rnd_pre_round,
    output logic [WORD_WIDTH*STATE_SIZE-1:0]    rnd_state,
    output logic [WORD_WIDTH*STATE_SIZE-1:0]    rnd_constants,
    input  logic [WORD_WIDTH*STATE_SIZE-1:0]    rnd_state_out,
    input  logic                                rnd_valid
);

    localparam int SW = WORD_WIDTH * STATE_SIZE;
    localparam int RW = $clog2(NUM_ROUNDS + 1);
    localparam int AW = $clog2(NUM_ROUNDS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);
    localparam logic [TW-1:0] WDOG_LIMIT = TW'(TIMEOUT - 1);

    ctrl_state_t   state;
    logic [SW-1:0] state_q;
    logic [SW-1:0] const_q;
    logic [RW-1:0] round;
    logic [RW-1:0] round_inc;
    logic [TW-1:0] wdog;
    logic [AW-1:0] addr_q;
    logic          fetch_phase;
    logic          pre_round_q;
    logic          error_q;

    assign round_inc = round + RW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            state_q     <= '0;
            const_q     <= '0;
            round       <= '0;
            wdog        <= '0;
            addr_q      <= '0;
            fetch_phase <= 1'b0;
            pre_round_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q     <= in_state;
                        const_q     <= '0;
                        round       <= '0;
                        pre_round_q <= 1'b1;
                        state       <= S_START;
                    end
                end
                // Two cycles: address out, then ROM data lands and is captured.
                S_FETCH: begin
                    fetch_phase <= ~fetch_phase;
                    if (fetch_phase) begin
                        const_q <= rc_data;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rnd_valid) begin
                        state_q <= rnd_state_out;
                        if (round == LAST_ROUND) begin
                            state <= S_DONE;
                        end else begin
                            round       <= round_inc;
                            pre_round_q <= 1'b0;
                            if (round_inc == LAST_ROUND) begin
                                const_q <= '0;
                                state   <= S_START;
                            end else begin
                                addr_q      <= AW'(round);
                                fetch_phase <= 1'b0;
                                state       <= S_FETCH;
                            end
                        end
                    end else if (wdog == WDOG_LIMIT) begin
                        error_q <= 1'b1;
                        state   <= S_FAIL;
                    end else begin
                        wdog <= wdog + TW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_FAIL: begin
                    state <= S_FAIL;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (state == S_IDLE);
    assign out_valid     = (state == S_DONE);
    assign out_state     = state_q;
    assign error         = error_q;
    assign rc_addr       = addr_q;
    assign rnd_reset     = reset | (state == S_START) | (state == S_FAIL);
    assign rnd_pre_round = pre_round_q;
    assign rnd_state     = state_q;
    assign rnd_constants = const_q;

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// Directed bench for monolith_perm_ctrl with behavioural round engine and ROM.
module tb_monolith_perm_ctrl;
    import monolith_pkg::*;

    localparam int W   = 31;
    localparam int S   = 16;
    localparam int SW  = W * S;
    localparam int NR  = 6;
    localparam int TO  = 64;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_state = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [SW-1:0] out_state;
    logic          error;
    logic [2:0]    rc_addr;
    logic [SW-1:0] rc_data;
    logic          rnd_reset;
    logic          rnd_pre_round;
    logic [SW-1:0] rnd_state;
    logic [SW-1:0] rnd_constants;
    logic [SW-1:0] rnd_state_out;
    logic          rnd_valid;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    monolith_perm_ctrl #(
        .WORD_WIDTH(W),
        .STATE_SIZE(S),
        .NUM_ROUNDS(NR),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_state(in_state),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_state(out_state),
        .error(error),
        .rc_addr(rc_addr),
        .rc_data(rc_data),
        .rnd_reset(rnd_reset),
        .rnd_pre_round(rnd_pre_round),
        .rnd_state(rnd_state),
        .rnd_constants(rnd_constants),
        .rnd_state_out(rnd_state_out),
        .rnd_valid(rnd_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM: every word of address a is a+1, one-cycle read latency.
    logic [W-1:0] rom_word;
    assign rom_word = W'(rc_addr) + W'(1);
    always @(posedge clk) rc_data <= {S{rom_word}};

    // Engine: out[i] = in[i] + c[i] + 1 mod p, valid LAT cycles after start.
    function automatic logic [SW-1:0] engine_f(input logic [SW-1:0] a, input logic [SW-1:0] c);
        logic [SW-1:0] r;
        longint unsigned t;
        for (int i = 0; i < S; i++) begin
            t = (longint'(a[i*W +: W]) + longint'(c[i*W +: W]) + 1) % longint'(PRIME);
            r[i*W +: W] = W'(t);
        end
        return r;
    endfunction

    logic [SW-1:0] eng_in, eng_c;
    logic          eng_busy, eng_valid;
    logic          eng_en = 1'b1;
    int            eng_cnt;
    always @(posedge clk) begin
        if (rnd_reset) begin
            eng_in    <= rnd_state;
            eng_c     <= rnd_constants;
            eng_busy  <= 1'b1;
            eng_cnt   <= 1;
            eng_valid <= 1'b0;
        end else if (eng_busy) begin
            if (eng_cnt == LAT - 1) begin
                eng_valid     <= 1'b1;
                eng_busy      <= 1'b0;
                rnd_state_out <= engine_f(eng_in, eng_c);
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end
    assign rnd_valid = eng_valid & eng_en;

    int   pulses, pre_pulses, last_valid_cyc, accept_cyc, out_cyc;
    logic first_pre, prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!reset && rnd_reset && !error) begin
            pulses = pulses + 1;
            if (rnd_pre_round) pre_pulses = pre_pulses + 1;
            if (pulses == 1) first_pre = rnd_pre_round;
        end
        if (rnd_valid && !prev_valid) last_valid_cyc = cyc;
        prev_valid = rnd_valid;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Drives one request at a negedge; returns at the negedge of the START cycle.
    task automatic start_perm(input logic [W-1:0] w);
        in_state   = {S{w}};
        in_valid   = 1'b1;
        pulses     = 0;
        pre_pulses = 0;
        first_pre  = 1'b0;
        accept_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        bit found = 0;
        for (int i = 0; i < 300; i++) begin
            if (out_valid) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        out_cyc = cyc;
        if (!found) begin
            checks++;
            fails++;
            $display("FAIL out_valid_timeout: got no out_valid within 300 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rnd_reset !== 1'b1) begin fails++; $display("FAIL reset_rnd_reset: got %b want 1", rnd_reset); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (rnd_pre_round !== 1'b0) begin fails++; $display("FAIL reset_pre_round: got %b want 0", rnd_pre_round); end
        checks++; if (rc_addr !== 3'd0) begin fails++; $display("FAIL reset_rc_addr: got %0d want 0", rc_addr); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_state !== '0) begin fails++; $display("FAIL reset_out_state: got %0h want 0", out_state); end
        checks++; if (rnd_reset !== 1'b0) begin fails++; $display("FAIL idle_rnd_reset: got %b want 0", rnd_reset); end
    endtask

    task automatic test_zero();
        logic [W-1:0] e = 31'd22;
        out_ready = 1'b1;
        start_perm('0);
        wait_out_valid();
        checks++; if (out_cyc - accept_cyc !== 39) begin fails++; $display("FAIL zero_latency: got %0d want 39", out_cyc - accept_cyc); end
        checks++; if (out_cyc !== last_valid_cyc + 1) begin fails++; $display("FAIL zero_engine_xcheck: got %0d want %0d", out_cyc, last_valid_cyc + 1); end
        checks++; if (out_state !== {S{e}}) begin fails++; $display("FAIL zero_out_state: got %0h want %0h", out_state, {S{e}}); end
        checks++; if (pulses !== 7) begin fails++; $display("FAIL zero_pulses: got %0d want 7", pulses); end
        checks++; if (pre_pulses !== 1) begin fails++; $display("FAIL zero_pre_pulses: got %0d want 1", pre_pulses); end
        checks++; if (first_pre !== 1'b1) begin fails++; $display("FAIL zero_first_pre: got %b want 1", first_pre); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL zero_return_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] e = 31'd21;
        start_perm(PRIME - 31'd1);
        wait_out_valid();
        checks++; if (out_state !== {S{e}}) begin fails++; $display("FAIL wrap_out_state: got %0h want %0h", out_state, {S{e}}); end
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [W-1:0] e = 31'd27;
        out_ready = 1'b0;
        start_perm(31'd5);
        wait_out_valid();
        in_state = {S{31'd9}};
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_out_valid: got %b want 1", out_valid); end
            checks++; if (out_state !== {S{e}}) begin fails++; $display("FAIL hold_out_state: got %0h want %0h", out_state, {S{e}}); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL hold_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_timeout();
        eng_en = 1'b0;
        start_perm('0);
        for (int k = 1; k <= 70; k++) begin
            if (k == 65) begin
                checks++; if (error !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b want 0", error); end
            end
            if (k == 66) begin
                checks++; if (error !== 1'b1) begin fails++; $display("FAIL timeout_error: got %b want 1", error); end
                in_valid = 1'b1;
            end
            if (k == 70) begin
                checks++; if (rnd_reset !== 1'b1) begin fails++; $display("FAIL timeout_rnd_reset: got %b want 1", rnd_reset); end
                checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL timeout_in_ready: got %b want 0", in_ready); end
                checks++; if (error !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b want 1", error); end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        eng_en   = 1'b1;
        do_reset();
        checks++; if (error !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL timeout_cleared: got error=%b in_ready=%b want 0 1", error, in_ready); end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] e = 31'd22;
        bit seen = 0;
        start_perm(31'd3);
        for (int i = 0; i < 100; i++) begin
            if (pulses == 4) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!seen) begin fails++; $display("FAIL midreset_reach_round3: got pulses=%0d want 4", pulses); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_idle: got %b want 1", in_ready); end
        checks++; if (rnd_reset !== 1'b1) begin fails++; $display("FAIL midreset_rnd_reset: got %b want 1", rnd_reset); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out_state !== '0) begin fails++; $display("FAIL midreset_discard: got %0h want 0", out_state); end
        start_perm('0);
        wait_out_valid();
        checks++; if (out_state !== {S{e}}) begin fails++; $display("FAIL midreset_result: got %0h want %0h", out_state, {S{e}}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e1 = 31'd23;
        logic [W-1:0] e2 = 31'd24;
        out_ready = 1'b1;
        start_perm(31'd1);
        in_state = {S{31'd2}};
        in_valid = 1'b1;
        wait_out_valid();
        checks++; if (out_state !== {S{e1}}) begin fails++; $display("FAIL b2b_first: got %0h want %0h", out_state, {S{e1}}); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle: got %b want 1", in_ready); end
        @(negedge clk);
        checks++; if (rnd_reset !== 1'b1 || rnd_pre_round !== 1'b1) begin fails++; $display("FAIL b2b_second_start: got rnd_reset=%b pre=%b want 1 1", rnd_reset, rnd_pre_round); end
        in_valid = 1'b0;
        wait_out_valid();
        checks++; if (out_state !== {S{e2}}) begin fails++; $display("FAIL b2b_second: got %0h want %0h", out_state, {S{e2}}); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_wrap();
        test_hold();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
